sparrow_data_mem: RTL

- Memory-side responder for the sparrow core data memory interface; it services the core's load/store requests.
- Word-organised, single-port, synchronous RAM model with byte/halfword/word access and address decode.
- Detects misaligned and out-of-range accesses, with a sticky error capture.
- Used in simulation top-levels and FPGA builds beside the core; a preload port lets the bench or boot logic fill contents.

---
 rtl/sparrow_data_mem.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/sparrow_data_mem.sv
// Data-memory responder for the sparrow core: single-port byte-lane RAM with
// size/alignment/range checking, sticky error capture and access counters.
module sparrow_data_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          DEPTH_WORDS = 1024,
    localparam int         AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          data_mem_req_i,
    input  logic [31:0]   data_mem_addr_i,
    input  logic [1:0]    data_mem_byte_en_i,
    input  logic          data_mem_wr_i,
    input  logic [31:0]   data_mem_wr_data_i,
    output logic [31:0]   data_mem_rd_data_o,
    input  logic          load_we_i,
    input  logic [AW-1:0] load_addr_i,
    input  logic [31:0]   load_data_i,
    output logic          err_o,
    output logic [31:0]   err_addr_o,
    output logic [31:0]   rd_cnt_o,
    output logic [31:0]   wr_cnt_o
);

    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    logic [31:0]   offset;
    logic [AW-1:0] word_idx;
    logic          in_range;
    logic          size_ok;
    logic          align_ok;
    logic          access_ok;
    logic          core_ok;
    logic          err_event;

    logic [3:0]    lane_mask;
    logic [31:0]   store_data;
    logic [3:0]    lane_we;
    logic [AW-1:0] lane_addr;
    logic [31:0]   lane_wdata;
    logic [31:0]   rd_word;
    logic [31:0]   load_fmt;

    logic [31:0]   rd_data_q, rd_data_d;
    logic          err_q, err_d;
    logic [31:0]   err_addr_q, err_addr_d;
    logic [31:0]   rd_cnt_q, rd_cnt_d;
    logic [31:0]   wr_cnt_q, wr_cnt_d;

    // Unsigned offset compare makes addresses below BASE wrap to huge values.
    always_comb begin
        offset    = data_mem_addr_i - BASE_ADDR;
        word_idx  = offset[AW+1:2];
        in_range  = offset < SPAN;
        size_ok   = data_mem_byte_en_i != 2'b10;
        case (data_mem_byte_en_i)
            2'b01:   align_ok = ~data_mem_addr_i[0];
            2'b11:   align_ok = data_mem_addr_i[1:0] == 2'b00;
            default: align_ok = 1'b1;
        endcase
        access_ok = in_range & size_ok & align_ok;
        core_ok   = data_mem_req_i & ~load_we_i & access_ok;
        err_event = data_mem_req_i & ~core_ok;
    end

    always_comb begin
        lane_mask  = 4'b0000;
        store_data = data_mem_wr_data_i;
        case (data_mem_byte_en_i)
            2'b00: begin
                lane_mask[data_mem_addr_i[1:0]] = 1'b1;
                store_data = {4{data_mem_wr_data_i[7:0]}};
            end
            2'b01: begin
                lane_mask  = data_mem_addr_i[1] ? 4'b1100 : 4'b0011;
                store_data = {2{data_mem_wr_data_i[15:0]}};
            end
            2'b11:   lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase

        // The preload port owns the RAM whenever it is strobed.
        if (load_we_i) begin
            lane_we    = 4'b1111;
            lane_addr  = load_addr_i;
            lane_wdata = load_data_i;
        end else begin
            lane_we    = (core_ok & data_mem_wr_i) ? lane_mask : 4'b0000;
            lane_addr  = word_idx;
            lane_wdata = store_data;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_q [DEPTH_WORDS];

            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    mem_q[lane_addr] <= lane_wdata[gi*8 +: 8];
                end
            end

            assign rd_word[gi*8 +: 8] = mem_q[word_idx];
        end
    endgenerate

    always_comb begin
        case (data_mem_byte_en_i)
            2'b00:   load_fmt = {24'b0, rd_word[{data_mem_addr_i[1:0], 3'b000} +: 8]};
            2'b01:   load_fmt = {16'b0, rd_word[{data_mem_addr_i[1], 4'b0000} +: 16]};
            default: load_fmt = rd_word;
        endcase
    end

    always_comb begin
        rd_data_d = rd_data_q;
        // A load colliding with preload holds; any other invalid load returns zero.
        if (data_mem_req_i & ~load_we_i & ~data_mem_wr_i) begin
            rd_data_d = access_ok ? load_fmt : 32'b0;
        end

        err_d      = err_q | err_event;
        err_addr_d = (err_event & ~err_q) ? data_mem_addr_i : err_addr_q;

        rd_cnt_d = rd_cnt_q;
        if (core_ok & ~data_mem_wr_i & (rd_cnt_q != 32'hFFFF_FFFF)) begin
            rd_cnt_d = rd_cnt_q + 32'd1;
        end
        wr_cnt_d = wr_cnt_q;
        if (core_ok & data_mem_wr_i & (wr_cnt_q != 32'hFFFF_FFFF)) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q  <= 32'b0;
            err_q      <= 1'b0;
            err_addr_q <= 32'b0;
            rd_cnt_q   <= 32'b0;
            wr_cnt_q   <= 32'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    assign data_mem_rd_data_o = rd_data_q;
    assign err_o              = err_q;
    assign err_addr_o         = err_addr_q;
    assign rd_cnt_o           = rd_cnt_q;
    assign wr_cnt_o           = wr_cnt_q;

endmodule
